// File: rtl/cascade_channel_sequencer.sv
// Tags core frame-finish events with a round-robin channel, pairs late results with
// their tags, averages 2^k results per channel and queues means behind valid/ready.
module cascade_channel_sequencer #(
   parameter int CHANELS       = 4,
   parameter int AC_WIDTH      = 32,
   parameter int PH_WIDTH      = 32,
   parameter int TAG_DEPTH     = 4,
   parameter int MAX_MEAN_LOG2 = 4,
   parameter int OUT_DEPTH     = 4,
   parameter int CH_W          = $clog2(CHANELS),
   parameter int K_W           = $clog2(MAX_MEAN_LOG2 + 1),
   parameter int TL_W          = $clog2(TAG_DEPTH + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [CH_W-1:0]            cfg_last_ch,
   input  logic [K_W-1:0]             cfg_mean_log2,
   input  logic                       cfg_clear,
   input  logic                       i_finish,
   input  logic                       i_vld,
   input  logic [AC_WIDTH-1:0]        i_ac,
   input  logic signed [PH_WIDTH-1:0] i_ph,
   output logic [CH_W-1:0]            address_registration,
   output logic [TL_W-1:0]            tag_level,
   output logic                       o_vld,
   input  logic                       o_rdy,
   output logic [CH_W-1:0]            o_addres,
   output logic [AC_WIDTH-1:0]        o_ac,
   output logic signed [PH_WIDTH-1:0] o_ph,
   output logic                       err_tag_ovf,
   output logic                       err_tag_udf,
   output logic                       err_out_ovf
);

   localparam int ACC_AC = AC_WIDTH + MAX_MEAN_LOG2;
   localparam int ACC_PH = PH_WIDTH + MAX_MEAN_LOG2;
   localparam int CNT_W  = MAX_MEAN_LOG2 + 1;
   localparam int TP_W   = $clog2(TAG_DEPTH);
   localparam int OP_W   = $clog2(OUT_DEPTH);
   localparam int OL_W   = $clog2(OUT_DEPTH + 1);

   function automatic logic [TP_W-1:0] tag_ptr_next(input logic [TP_W-1:0] p);
      return (p == TP_W'(TAG_DEPTH - 1)) ? '0 : p + TP_W'(1);
   endfunction

   function automatic logic [OP_W-1:0] out_ptr_next(input logic [OP_W-1:0] p);
      return (p == OP_W'(OUT_DEPTH - 1)) ? '0 : p + OP_W'(1);
   endfunction

   logic [CH_W-1:0]          r_addr;
   logic [CH_W-1:0]          r_tag_mem [TAG_DEPTH];
   logic [TP_W-1:0]          r_tag_rd, r_tag_wr;
   logic [TL_W-1:0]          r_tag_cnt;
   logic [ACC_AC-1:0]        r_ac_sum [CHANELS];
   logic signed [ACC_PH-1:0] r_ph_sum [CHANELS];
   logic [CNT_W-1:0]         r_cnt [CHANELS];
   logic                     r_p_vld;
   logic [CH_W-1:0]          r_p_ch;
   logic [AC_WIDTH-1:0]      r_p_ac;
   logic [PH_WIDTH-1:0]      r_p_ph;
   logic [CH_W-1:0]          r_out_ch [OUT_DEPTH];
   logic [AC_WIDTH-1:0]      r_out_ac [OUT_DEPTH];
   logic [PH_WIDTH-1:0]      r_out_ph [OUT_DEPTH];
   logic [OP_W-1:0]          r_out_rd, r_out_wr;
   logic [OL_W-1:0]          r_out_cnt;
   logic                     r_err_tag_ovf, r_err_tag_udf, r_err_out_ovf;

   logic [CH_W-1:0]          w_last_ch;
   logic [K_W-1:0]           w_k;
   logic                     w_run, w_tag_empty, w_tag_full;
   logic                     w_pop, w_push, w_tag_ovf_ev, w_tag_udf_ev;
   logic [CH_W-1:0]          w_tag;
   logic [ACC_AC-1:0]        w_ac_sum;
   logic signed [ACC_PH-1:0] w_ph_sum;
   logic [CNT_W-1:0]         w_target;
   logic                     w_done;
   logic                     w_out_full, w_out_pop, w_out_push, w_out_ovf_ev;

   assign w_last_ch = (cfg_last_ch >= CH_W'(CHANELS - 1)) ? CH_W'(CHANELS - 1) : cfg_last_ch;
   assign w_k       = (cfg_mean_log2 > K_W'(MAX_MEAN_LOG2)) ? K_W'(MAX_MEAN_LOG2) : cfg_mean_log2;

   // A result arriving with no tag outstanding is dropped even if a tag is pushed this cycle.
   assign w_run        = !cfg_clear;
   assign w_tag_empty  = (r_tag_cnt == TL_W'(0));
   assign w_tag_full   = (r_tag_cnt == TL_W'(TAG_DEPTH));
   assign w_pop        = w_run & i_vld & !w_tag_empty;
   assign w_push       = w_run & i_finish & (!w_tag_full | w_pop);
   assign w_tag_ovf_ev = w_run & i_finish & w_tag_full & !w_pop;
   assign w_tag_udf_ev = w_run & i_vld & w_tag_empty;
   assign w_tag        = r_tag_mem[r_tag_rd];

   assign w_ac_sum = r_ac_sum[w_tag] + ACC_AC'(i_ac);
   assign w_ph_sum = r_ph_sum[w_tag] + ACC_PH'(i_ph);
   assign w_target = (CNT_W'(1) << w_k) - CNT_W'(1);
   assign w_done   = (r_cnt[w_tag] >= w_target);

   assign w_out_full   = (r_out_cnt == OL_W'(OUT_DEPTH));
   assign w_out_pop    = o_vld & o_rdy;
   assign w_out_push   = r_p_vld & (!w_out_full | w_out_pop);
   assign w_out_ovf_ev = r_p_vld & w_out_full & !w_out_pop;

   // Address counter, tag FIFO and error flags.
   always_ff @(posedge clk) begin
      if (rst || cfg_clear) begin
         r_addr        <= '0;
         r_tag_rd      <= '0;
         r_tag_wr      <= '0;
         r_tag_cnt     <= '0;
         r_err_tag_ovf <= 1'b0;
         r_err_tag_udf <= 1'b0;
         for (int i = 0; i < TAG_DEPTH; i++) r_tag_mem[i] <= '0;
      end else begin
         if (i_finish) begin
            r_addr <= (r_addr >= w_last_ch) ? '0 : r_addr + CH_W'(1);
         end
         if (w_push) begin
            r_tag_mem[r_tag_wr] <= r_addr;
            r_tag_wr            <= tag_ptr_next(r_tag_wr);
         end
         if (w_pop) r_tag_rd <= tag_ptr_next(r_tag_rd);
         r_tag_cnt <= r_tag_cnt + TL_W'(w_push) - TL_W'(w_pop);
         if (w_tag_ovf_ev) r_err_tag_ovf <= 1'b1;
         if (w_tag_udf_ev) r_err_tag_udf <= 1'b1;
      end
   end

   // Per-channel accumulators; a completed group is staged for one cycle.
   always_ff @(posedge clk) begin
      if (rst || cfg_clear) begin
         for (int c = 0; c < CHANELS; c++) begin
            r_ac_sum[c] <= '0;
            r_ph_sum[c] <= '0;
            r_cnt[c]    <= '0;
         end
         r_p_vld <= 1'b0;
         if (rst) begin
            r_p_ch <= '0;
            r_p_ac <= '0;
            r_p_ph <= '0;
         end
      end else begin
         r_p_vld <= w_pop & w_done;
         if (w_pop) begin
            if (w_done) begin
               r_ac_sum[w_tag] <= '0;
               r_ph_sum[w_tag] <= '0;
               r_cnt[w_tag]    <= '0;
               r_p_ch          <= w_tag;
               r_p_ac          <= AC_WIDTH'(w_ac_sum >> w_k);
               r_p_ph          <= PH_WIDTH'(w_ph_sum >>> w_k);
            end else begin
               r_ac_sum[w_tag] <= w_ac_sum;
               r_ph_sum[w_tag] <= w_ph_sum;
               r_cnt[w_tag]    <= r_cnt[w_tag] + CNT_W'(1);
            end
         end
      end
   end

   // Output FIFO survives cfg_clear; only reset empties it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_rd  <= '0;
         r_out_wr  <= '0;
         r_out_cnt <= '0;
         for (int i = 0; i < OUT_DEPTH; i++) begin
            r_out_ch[i] <= '0;
            r_out_ac[i] <= '0;
            r_out_ph[i] <= '0;
         end
      end else begin
         if (w_out_push) begin
            r_out_ch[r_out_wr] <= r_p_ch;
            r_out_ac[r_out_wr] <= r_p_ac;
            r_out_ph[r_out_wr] <= r_p_ph;
            r_out_wr           <= out_ptr_next(r_out_wr);
         end
         if (w_out_pop) r_out_rd <= out_ptr_next(r_out_rd);
         r_out_cnt <= r_out_cnt + OL_W'(w_out_push) - OL_W'(w_out_pop);
      end
   end

   // Output overflow flag.
   always_ff @(posedge clk) begin
      if (rst || cfg_clear) begin
         r_err_out_ovf <= 1'b0;
      end else if (w_out_ovf_ev) begin
         r_err_out_ovf <= 1'b1;
      end else begin
         r_err_out_ovf <= r_err_out_ovf;
      end
   end

   assign address_registration = r_addr;
   assign tag_level            = r_tag_cnt;
   assign o_vld                = (r_out_cnt != OL_W'(0));
   assign o_addres             = o_vld ? r_out_ch[r_out_rd] : '0;
   assign o_ac                 = o_vld ? r_out_ac[r_out_rd] : '0;
   assign o_ph                 = o_vld ? r_out_ph[r_out_rd] : '0;
   assign err_tag_ovf          = r_err_tag_ovf;
   assign err_tag_udf          = r_err_tag_udf;
   assign err_out_ovf          = r_err_out_ovf;

endmodule

// File: tb/tb_cascade_channel_sequencer.sv
// Randomized and directed bench for cascade_channel_sequencer against a queue-based model.
module tb_cascade_channel_sequencer;

   localparam int NCH  = 4;
   localparam int TAGD = 4;
   localparam int OUTD = 4;
   localparam int MAXK = 4;

   logic        clk = 1'b0;
   logic        rst, cfg_clear, i_finish, i_vld, o_rdy;
   logic [1:0]  cfg_last_ch;
   logic [2:0]  cfg_mean_log2;
   logic [31:0] i_ac, i_ph;
   logic [1:0]  address_registration, o_addres;
   logic [2:0]  tag_level;
   logic        o_vld, err_tag_ovf, err_tag_udf, err_out_ovf;
   logic [31:0] o_ac, o_ph;

   cascade_channel_sequencer dut (
      .clk(clk), .rst(rst), .cfg_last_ch(cfg_last_ch), .cfg_mean_log2(cfg_mean_log2),
      .cfg_clear(cfg_clear), .i_finish(i_finish), .i_vld(i_vld), .i_ac(i_ac), .i_ph(i_ph),
      .address_registration(address_registration), .tag_level(tag_level), .o_vld(o_vld),
      .o_rdy(o_rdy), .o_addres(o_addres), .o_ac(o_ac), .o_ph(o_ph),
      .err_tag_ovf(err_tag_ovf), .err_tag_udf(err_tag_udf), .err_out_ovf(err_out_ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          ch;
      logic [31:0] ac;
      logic [31:0] ph;
   } res_t;

   int     n_checks = 0;
   int     n_fail   = 0;
   int     m_addr;
   int     tagq[$];
   longint m_ac[NCH];
   longint m_ph[NCH];
   int     m_cnt[NCH];
   res_t   outq[$];
   bit     p_vld;
   res_t   p_res;
   bit     e_to, e_tu, e_oo;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   // Reference model: advance one clock using the inputs currently applied.
   task automatic model_step();
      int last, k, c;
      last = (cfg_last_ch >= 2'(NCH - 1)) ? NCH - 1 : int'(cfg_last_ch);
      k    = (cfg_mean_log2 > 3'(MAXK)) ? MAXK : int'(cfg_mean_log2);
      if (rst) begin
         m_addr = 0; tagq.delete(); outq.delete(); p_vld = 0;
         e_to = 0; e_tu = 0; e_oo = 0;
         for (int i = 0; i < NCH; i++) begin m_ac[i] = 0; m_ph[i] = 0; m_cnt[i] = 0; end
         return;
      end
      if (outq.size() > 0 && o_rdy) void'(outq.pop_front());
      if (p_vld) begin
         if (outq.size() < OUTD) outq.push_back(p_res);
         else e_oo = 1;
      end
      p_vld = 0;
      if (cfg_clear) begin
         m_addr = 0; tagq.delete(); e_to = 0; e_tu = 0; e_oo = 0;
         for (int i = 0; i < NCH; i++) begin m_ac[i] = 0; m_ph[i] = 0; m_cnt[i] = 0; end
         return;
      end
      if (i_vld) begin
         if (tagq.size() == 0) e_tu = 1;
         else begin
            c = tagq.pop_front();
            m_ac[c] += longint'(i_ac);
            m_ph[c] += longint'($signed(i_ph));
            m_cnt[c]++;
            if (m_cnt[c] >= (1 << k)) begin
               p_vld    = 1;
               p_res.ch = c;
               p_res.ac = 32'(m_ac[c] / (longint'(1) << k));
               p_res.ph = 32'(m_ph[c] >>> k);
               m_ac[c] = 0; m_ph[c] = 0; m_cnt[c] = 0;
            end
         end
      end
      if (i_finish) begin
         if (tagq.size() < TAGD) tagq.push_back(m_addr);
         else e_to = 1;
         m_addr = (m_addr >= last) ? 0 : m_addr + 1;
      end
   endtask

   task automatic compare_all();
      check_val("addr", 64'(address_registration), 64'(m_addr));
      check_val("tag_level", 64'(tag_level), 64'(tagq.size()));
      check_val("o_vld", 64'(o_vld), 64'(outq.size() > 0));
      if (outq.size() > 0) begin
         check_val("o_addres", 64'(o_addres), 64'(outq[0].ch));
         check_val("o_ac", 64'(o_ac), 64'(outq[0].ac));
         check_val("o_ph", 64'(o_ph), 64'(outq[0].ph));
      end
      check_val("err_tag_ovf", 64'(err_tag_ovf), 64'(e_to));
      check_val("err_tag_udf", 64'(err_tag_udf), 64'(e_tu));
      check_val("err_out_ovf", 64'(err_out_ovf), 64'(e_oo));
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic set_cfg(input logic [1:0] last, input logic [2:0] k);
      cfg_last_ch = last; cfg_mean_log2 = k; cfg_clear = 1'b1;
      i_finish = 1'b0; i_vld = 1'b0;
      tick();
      cfg_clear = 1'b0;
   endtask

   task automatic finish_then_result(input logic [31:0] ac, input logic [31:0] ph);
      i_finish = 1'b1; tick(); i_finish = 1'b0;
      i_vld = 1'b1; i_ac = ac; i_ph = ph; tick(); i_vld = 1'b0;
   endtask

   task automatic random_cycles(input int n, input bit hold_rdy_low);
      for (int i = 0; i < n; i++) begin
         i_finish  = ($urandom_range(0, 2) == 0);
         i_vld     = (tagq.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 39) == 0);
         o_rdy     = hold_rdy_low ? 1'b0 : ($urandom_range(0, 3) != 0);
         i_ac      = $urandom;
         i_ph      = $urandom;
         cfg_clear = ($urandom_range(0, 199) == 0);
         tick();
      end
      cfg_clear = 1'b0; i_finish = 1'b0; i_vld = 1'b0;
   endtask

   initial begin
      rst = 1'b1; cfg_clear = 1'b0; i_finish = 1'b0; i_vld = 1'b0; o_rdy = 1'b1;
      cfg_last_ch = 2'd3; cfg_mean_log2 = 3'd0; i_ac = 32'd0; i_ph = 32'd0;
      @(negedge clk);
      tick(); tick();
      check_val("rst_o_vld", 64'(o_vld), 64'd0);
      check_val("rst_o_ac", 64'(o_ac), 64'd0);
      check_val("rst_o_ph", 64'(o_ph), 64'd0);
      check_val("rst_o_addres", 64'(o_addres), 64'd0);
      rst = 1'b0;
      tick();

      // Tag overflow then underflow.
      i_finish = 1'b1;
      repeat (5) tick();
      i_finish = 1'b0;
      check_val("ovf_level", 64'(tag_level), 64'd4);
      check_val("ovf_flag", 64'(err_tag_ovf), 64'd1);
      check_val("ovf_addr", 64'(address_registration), 64'd1);
      for (int n = 0; n < 5; n++) begin
         i_vld = 1'b1; i_ac = 32'(100 + n); i_ph = 32'(-n); tick();
      end
      i_vld = 1'b0;
      tick();
      check_val("udf_flag", 64'(err_tag_udf), 64'd1);
      repeat (3) tick();

      // k=2 averaging on two channels, outputs held.
      set_cfg(2'd1, 3'd2);
      o_rdy = 1'b0;
      for (int n = 0; n < 8; n++) begin
         if (n % 2 == 0) finish_then_result(32'(4 * (n / 2 + 1)), (n == 6) ? -32'sd3 : 32'(-(n / 2 + 1)));
         else            finish_then_result(32'(n / 2 + 1), 32'(n / 2 + 5));
      end
      tick(); tick();
      check_val("mean_ch0_addr", 64'(o_addres), 64'd0);
      check_val("mean_ch0_ac", 64'(o_ac), 64'd10);
      check_val("mean_ch0_ph", 64'(o_ph), 64'(32'hFFFF_FFFD));
      o_rdy = 1'b1;
      tick();
      check_val("mean_ch1_addr", 64'(o_addres), 64'd1);
      check_val("mean_ch1_ac", 64'(o_ac), 64'd2);
      check_val("mean_ch1_ph", 64'(o_ph), 64'd6);
      tick();

      // Output FIFO overflow with o_rdy low.
      set_cfg(2'd3, 3'd0);
      o_rdy = 1'b0;
      for (int n = 0; n < 5; n++) finish_then_result(32'(200 + n), 32'(n));
      tick(); tick();
      check_val("oovf_flag", 64'(err_out_ovf), 64'd1);
      check_val("oovf_vld", 64'(o_vld), 64'd1);
      check_val("oovf_head", 64'(o_ac), 64'd200);
      o_rdy = 1'b1;
      repeat (5) tick();

      // Shrinking cfg_last_ch mid-rotation.
      set_cfg(2'd3, 3'd0);
      i_finish = 1'b1; tick(); tick();
      cfg_last_ch = 2'd1;
      tick();
      i_finish = 1'b0;
      check_val("shrink_wrap", 64'(address_registration), 64'd0);
      i_vld = 1'b1; i_ac = 32'd7; i_ph = 32'd9;
      repeat (3) tick();
      i_vld = 1'b0;
      repeat (3) tick();

      // Randomized runs over several configurations, including clipped k.
      set_cfg(2'd3, 3'd0); random_cycles(400, 1'b0);
      set_cfg(2'd1, 3'd2); random_cycles(400, 1'b0);
      set_cfg(2'd2, 3'd3); random_cycles(400, 1'b0);
      set_cfg(2'd3, 3'd6); random_cycles(600, 1'b0);
      set_cfg(2'd0, 3'd1); random_cycles(300, 1'b0);

      // Reset with outputs queued, then a clean run.
      set_cfg(2'd3, 3'd0);
      for (int i = 0; i < 300 && outq.size() < 2; i++) random_cycles(1, 1'b1);
      rst = 1'b1;
      tick();
      check_val("rst2_o_vld", 64'(o_vld), 64'd0);
      check_val("rst2_o_ac", 64'(o_ac), 64'd0);
      check_val("rst2_level", 64'(tag_level), 64'd0);
      rst = 1'b0;
      set_cfg(2'd1, 3'd1); random_cycles(300, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cascade_channel_sequencer.md
Name: cascade_channel_sequencer

Overview:
Parametrised successor to the fixed 4-channel computing-cascade tagging/averaging path. It sits between a variable-latency per-frame AC/PH core and downstream consumers. It tags each frame-finish event with a round-robin channel address, queues the tags, and pairs each late-arriving result with its tag. It averages 2^k results per channel and delivers means through a buffered valid/ready output, with sticky error reporting.

Parameters:
CHANELS, 4, maximum channel count (>=2); CH_W = $clog2(CHANELS)
AC_WIDTH, 32, unsigned amplitude width
PH_WIDTH, 32, signed phase width
TAG_DEPTH, 4, tag FIFO depth (>=2); must cover frames in flight inside the core
MAX_MEAN_LOG2, 4, largest averaging exponent; accumulators are width+MAX_MEAN_LOG2 bits
OUT_DEPTH, 4, output FIFO depth (>=2)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
cfg_last_ch  in  CH_W  index of last active channel (active count - 1); values >= CHANELS-1 mean CHANELS-1
cfg_mean_log2  in  $clog2(MAX_MEAN_LOG2+1)  averaging exponent k; values above MAX_MEAN_LOG2 clip to MAX_MEAN_LOG2
cfg_clear  in  1  single-cycle soft clear
i_finish  in  1  core has closed a frame (tag event)
i_vld  in  1  core result valid (no backpressure to core)
i_ac  in  AC_WIDTH  amplitude
i_ph  in  PH_WIDTH  signed phase
address_registration  out  CH_W  channel the next i_finish will be tagged with
tag_level  out  $clog2(TAG_DEPTH+1)  tags in flight
o_vld  out  1  output valid
o_rdy  in  1  downstream ready
o_addres  out  CH_W  channel of output mean
o_ac  out  AC_WIDTH  mean amplitude
o_ph  out  PH_WIDTH  signed mean phase
err_tag_ovf  out  1  sticky: i_finish while tag FIFO full with no pop
err_tag_udf  out  1  sticky: i_vld while tag FIFO empty
err_out_ovf  out  1  sticky: mean dropped because output FIFO full

Behaviour:
- Reset (rst=1): address_registration=0, tag_level=0, all accumulators and counts=0, output FIFO empty, o_vld=0, o_addres/o_ac/o_ph=0, all err_*=0.
- Address counter:
  - On i_finish, the current address_registration is pushed as the tag.
  - The counter then increments, wrapping to 0 when it is >= the effective cfg_last_ch. A shrunken cfg therefore wraps on the next event and never stalls.
- Tag FIFO:
  - Push on i_finish; pop on i_vld. The popped tag is the channel for that result.
  - Simultaneous push and pop when full: both occur, level unchanged, no error.
  - Push when full without pop: tag discarded, address still advances, err_tag_ovf set.
  - Pop when empty, including a same-cycle push: result dropped, FIFO receives the push, err_tag_udf set.
- Accumulation:
  - Per channel c: ac_sum[c] is unsigned AC_WIDTH+MAX_MEAN_LOG2; ph_sum[c] is signed PH_WIDTH+MAX_MEAN_LOG2 (sign-extended add); cnt[c] counts results.
  - A result completes a group when cnt[c] == 2^k - 1. On completion the mean is ac_sum>>k (logical) and ph_sum>>>k (arithmetic, truncates toward -inf). It is pushed with tag c to the output FIFO; sums and cnt for c clear.
  - k=0 is pass-through: every result is emitted unchanged.
  - Sums use a registered stage: the result accepted at edge E is pushed to the output FIFO at edge E+1. o_vld rises in the cycle after E+1 if the FIFO was empty (2-cycle latency).
- Output FIFO:
  - Standard valid/ready. A transfer occurs when o_vld & o_rdy; data holds stable while o_vld & !o_rdy.
  - Push at full with no same-cycle pop: mean dropped, err_out_ovf set, channel accumulator still cleared.
- Config: cfg_* may change at any time. A k change mid-group applies to the in-progress count as-is. Software changes cfg only alongside cfg_clear.
- cfg_clear:
  - Clears address counter, tag FIFO, accumulators, cnt and err_*.
  - Output FIFO contents and the pipeline stage are preserved.
  - i_finish/i_vld in the same cycle are ignored.
- Reset mid-operation discards everything, including output FIFO contents.

Test Plan:
- CHANELS=4, cfg_last_ch=3, k=0: 8 i_finish pulses, each followed 5 cycles later by i_vld with i_ac=100+n, i_ph=-n -> outputs on channels 0,1,2,3,0,1,2,3 with ac=100..107 and ph=0..-7, each 2 cycles after its i_vld; o_rdy held 1.
- k=2, cfg_last_ch=1: 8 results, channel 0 ac=4,8,12,16 and ph=-1,-2,-3,-3 -> one ch0 output ac=10, ph=-3 (-9>>>2); ch1 output emitted after its 4th result.
- TAG_DEPTH=4: 5 i_finish with no i_vld -> tag_level=4, err_tag_ovf=1, address_registration=1; then i_vld with empty tags after 4 pops -> err_tag_udf=1.
- o_rdy=0, k=0, OUT_DEPTH=4: 5 results -> 4 held with o_vld=1 and data stable, err_out_ovf=1; raise o_rdy -> 4 in-order transfers.
- cfg_last_ch changed 3->1 while address_registration=2 -> next i_finish tags 2, then counter wraps to 0; cfg_clear mid-group -> address=0, next 2^k results form a fresh mean; queued outputs survive.
- rst asserted with 2 outputs queued and partial sums -> all outputs 0 next cycle; a subsequent group produces clean means.
